// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide unit with HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-step combinational multiply.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  state_e state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opd_q, opd_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
  logic accept, go, fast_mul, a_neg, b_neg, ge;
  logic [WIDTH-1:0] abs_a, abs_b, quo, rem, diff, res_hi, res_lo;
  logic [WIDTH:0] sum, sh;
  logic [2*WIDTH-1:0] load_v, mul_step, div_step, prod;
  assign accept = start && !busy;
  assign go     = accept && !op[2];
  assign a_neg  = !op[0] && a[WIDTH-1];
  assign b_neg  = !op[0] && b[WIDTH-1];
  assign abs_a  = a_neg ? -a : a;
  assign abs_b  = b_neg ? -b : b;
`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = !op[1];
  assign load_v   = op[1] ? {{WIDTH{1'b0}}, abs_a}
                          : {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`else
  assign fast_mul = 1'b0;
  assign load_v   = {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
`endif
  // Multiply: upper half accumulates, lower half holds the multiplier shifting out LSB first.
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_step = {sum, acc_q[WIDTH-1:1]};
  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign sh       = acc_q[2*WIDTH-1:WIDTH-1];
  assign ge       = sh >= {1'b0, opd_q};
  assign diff     = sh[WIDTH-1:0] - opd_q;
  assign div_step = {ge ? diff : sh[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
  assign prod     = neg_q ? -acc_q : acc_q;
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
  assign res_lo   = !div_q ? prod[WIDTH-1:0] : dz_q ? '1 : neg_q ? -quo : quo;
  assign res_hi   = !div_q ? prod[2*WIDTH-1:WIDTH] : rneg_q ? -rem : rem;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && go) state_d = fast_mul ? FIX : RUN;
    else if (state_q == RUN && cnt_q == '0) state_d = FIX;
    else if (state_q == FIX) state_d = IDLE;
  end
  // done is registered so it coincides with the HI/LO update; busy covers that cycle too.
  always_comb begin
    busy = (state_q != IDLE) || done_q;
    done = done_q;
  end
  always_comb begin
    acc_d  = acc_q;
    opd_d  = opd_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    if (go) begin
      acc_d  = load_v;
      opd_d  = op[1] ? abs_b : abs_a;
      cnt_d  = CW'(WIDTH-1);
      div_d  = op[1];
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      dz_d   = op[1] && (b == '0);
    end else if (state_q == RUN) begin
      acc_d = div_q ? div_step : mul_step;
      cnt_d = cnt_q - CW'(1);
    end
    done_d = state_q == FIX;
    hi_d   = (state_q == FIX) ? res_hi : (accept && op == 3'd4) ? a : hi_q;
    lo_d   = (state_q == FIX) ? res_lo : (accept && op == 3'd5) ? a : lo_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opd_q  <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      opd_q  <= opd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      done_q <= done_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, start, busy, done;
  logic [2:0] op;
  logic [W-1:0] a, b, hi, lo;
  int cyc = 0, checks = 0, errors = 0;
  logic [W-1:0] mhi = '0, mlo = '0;
  typedef struct {logic [W-1:0] hi; logic [W-1:0] lo; int due;} exp_t;
  exp_t sb[$];
  exp_t e;
  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
    endcase
  endfunction
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", {hi, lo}, {e.hi, e.lo});
        chk("done_time", 64'(cyc), 64'(e.due));
      end
    end
  end
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int noise);
    int n, lat;
    logic [63:0] r;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    n = cyc + 1;
    lat = (FAST && o < 3'd2) ? 1 : W + 1;
    r = model(o, x, y);
    sb.push_back('{r[63:32], r[31:0], n + lat});
    mhi = r[63:32];
    mlo = r[31:0];
    @(negedge clk);
    chk("busy_rise", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 200 && busy; i++) begin
      start = (i < noise);
      op = 3'($urandom);
      a = $urandom;
      b = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_fall", 64'(cyc), 64'(n + lat + 1));
    chk("hold", {hi, lo}, {mhi, mlo});
  endtask
  task automatic mt(input logic [2:0] o, input logic [W-1:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x;
    @(negedge clk);
    start = 1'b0;
    if (o == 3'd4) mhi = x;
    else if (o == 3'd5) mlo = x;
    chk("mt_hilo", {hi, lo}, {mhi, mlo});
    chk("mt_busy_done", {62'd0, busy, done}, 64'd0);
  endtask
  initial begin
    logic [2:0] o;
    logic [W-1:0] x, y;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    rst_n = 1'b1;
    mt(3'd4, 32'h1234_5678);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd3, 32'd100, 32'd7, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd3, 32'd42, 32'd0, 0);
    run_op(3'd2, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd1, 32'd6, 32'd7, 0);
    mt(3'd5, 32'hCAFE_F00D);
    mt(3'd6, 32'h1111_1111);
    mt(3'd7, 32'h2222_2222);
    run_op(3'd3, 32'd9, 32'd2, 5);
    mt(3'd4, 32'hDEAD_BEEF);
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("midrun_rst_hilo", {hi, lo}, 64'd0);
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 5) @(negedge clk);
    chk("post_rst_hold", {hi, lo}, 64'd0);
    repeat (40) begin
      o = 3'($urandom_range(0, 3));
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 9) == 0) y = 32'hFFFF_FFFF;
      run_op(o, x, y, $urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) mt(3'($urandom_range(4, 7)), $urandom);
    end
    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
